// File: rtl/shift_sequencer_if.sv
// Command handshake between an issuing master and the shift sequencer.
interface shift_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [0:1]       CMD_OP;
  logic [0:1]       CMD_FILL;
  logic [0:CNT_W-1] CMD_COUNT;

  modport master (
    output CMD_VALID, CMD_OP, CMD_FILL, CMD_COUNT,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_FILL, CMD_COUNT,
    output CMD_READY
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer for a chain of 4-bit universal shift registers: turns one
// load/shift/no-op command into per-cycle SEL codes and serial fill bits.
module shift_sequencer #(
  parameter int CNT_W = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  shift_sequencer_if.slave cmd,
  input  logic        Q_MSB,
  input  logic        Q_MSB1,
  input  logic        Q_LSB,
  output logic [0:1]  SEL,
  output logic        S0,
  output logic        S3,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVF
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FILL_ZERO  = 2'b00,
    FILL_ONES  = 2'b01,
    FILL_ROT   = 2'b10,
    FILL_ARITH = 2'b11
  } fill_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  fill_e            fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      fill_q  <= FILL_ZERO;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    fill_d        = fill_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    cmd.CMD_READY = (state_q == ST_IDLE) && !RESET;
    accept        = cmd.CMD_VALID && cmd.CMD_READY;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op_e'(cmd.CMD_OP);
          fill_d = fill_e'(cmd.CMD_FILL);
          cnt_d  = cmd.CMD_COUNT;
          ovf_d  = 1'b0;
          case (op_e'(cmd.CMD_OP))
            OP_LOAD: state_d = ST_LOAD;
            OP_SHR,
            OP_SHL:  state_d = (cmd.CMD_COUNT != '0) ? ST_SHIFT : ST_FIN;
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_LOAD: state_d = ST_FIN;
      ST_SHIFT: begin
        // Overflow: the bit about to become the sign differs from the sign.
        if (op_q == OP_SHL && fill_q == FILL_ARITH && Q_MSB != Q_MSB1)
          ovf_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    SEL  = 2'b11;
    S0   = 1'b0;
    S3   = 1'b0;
    BUSY = (state_q != ST_IDLE);
    DONE = (state_q == ST_FIN);
    OVF  = ovf_q;

    case (state_q)
      ST_LOAD: SEL = 2'b00;
      ST_SHIFT: begin
        if (op_q == OP_SHR) begin
          SEL = 2'b01;
          case (fill_q)
            FILL_ZERO: S0 = 1'b0;
            FILL_ONES: S0 = 1'b1;
            FILL_ROT:  S0 = Q_LSB;
            default:   S0 = Q_MSB;
          endcase
        end else begin
          SEL = 2'b10;
          case (fill_q)
            FILL_ONES: S3 = 1'b1;
            FILL_ROT:  S3 = Q_MSB;
            default:   S3 = 1'b0;
          endcase
        end
      end
      default: SEL = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: drives an 8-bit chain model and checks each
// command against an arithmetic model of load/shift/fill/overflow.
module tb_shift_sequencer;
  localparam int CNT_W = 6;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] q = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic [0:1] sel;
  logic       s0, s3, busy, done, ovf;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_done  = 0;
  int         cyc     = 0;

  always #5 CLK = ~CLK;

  shift_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .cmd    (cmd_if),
    .Q_MSB  (q[7]),
    .Q_MSB1 (q[6]),
    .Q_LSB  (q[0]),
    .SEL    (sel),
    .S0     (s0),
    .S3     (s3),
    .BUSY   (busy),
    .DONE   (done),
    .OVF    (ovf)
  );

  // Chain bit 0 (leftmost) is q[7]; SHR moves toward the LSB end.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    case (sel)
      2'b00:   q <= load_data;
      2'b01:   q <= {s0, q[7:1]};
      2'b10:   q <= {q[6:0], s3};
      default: q <= q;
    endcase
  end

  always @(negedge CLK) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n % 8; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  function automatic logic [7:0] model_q(input logic [1:0] op, input logic [1:0] fill,
                                         input int n, input logic [7:0] v, input logic [7:0] d);
    logic [7:0] t;
    t = ~v;
    case (op)
      2'b00: return d;
      2'b01: case (fill)
               2'b00:   return v >> n;
               2'b01:   begin t = t >> n; return ~t; end
               2'b10:   return rotr(v, n);
               default: return 8'($signed(v) >>> n);
             endcase
      2'b10: case (fill)
               2'b01:   begin t = t << n; return ~t; end
               2'b10:   return rotr(v, 8 - (n % 8));
               default: return v << n;
             endcase
      default: return v;
    endcase
  endfunction

  // Overflow iff any of the n bits that pass through the sign position differ from it.
  function automatic logic model_ovf(input logic [7:0] v, input int n);
    logic [71:0] e;
    e = {v, 64'h0};
    for (int i = 1; i <= n; i++) if (e[71-i] != e[71]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fill(input logic [1:0] op, input logic [1:0] fill,
                                            input logic [7:0] v);
    if (op == 2'b01)
      case (fill)
        2'b00: return 2'b00;
        2'b01: return 2'b10;
        2'b10: return {v[0], 1'b0};
        default: return {v[7], 1'b0};
      endcase
    if (op == 2'b10)
      case (fill)
        2'b01: return 2'b01;
        2'b10: return {1'b0, v[7]};
        default: return 2'b00;
      endcase
    return 2'b00;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] fill, input int n,
                         input logic [7:0] d);
    int         t, k, exp_lat;
    logic [7:0] qexp;
    logic       oexp;
    logic [1:0] code;
    @(negedge CLK);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_FILL  = fill;
    cmd_if.CMD_COUNT = CNT_W'(n);
    load_data        = d;
    t = 0;
    while (!cmd_if.CMD_READY && t < 20) begin @(negedge CLK); t++; end
    if (!cmd_if.CMD_READY) begin
      check("accept_tmo", 32'(0), 32'(1));
      cmd_if.CMD_VALID = 1'b0;
      return;
    end
    qexp    = model_q(op, fill, n, q, d);
    oexp    = (op == 2'b10 && fill == 2'b11) ? model_ovf(q, n) : 1'b0;
    exp_lat = (op == 2'b00) ? 2 : (op == 2'b11 || n == 0) ? 1 : n + 1;
    code    = (op == 2'b00) ? 2'b00 : (op == 2'b01) ? 2'b01 : 2'b10;
    @(posedge CLK);
    #1;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'($urandom);
    cmd_if.CMD_FILL  = 2'($urandom);
    cmd_if.CMD_COUNT = CNT_W'($urandom);
    for (k = 1; k <= 80; k++) begin
      @(negedge CLK);
      if (k == 1) check("ovf_clr", 32'(ovf), 32'(0));
      if (done) break;
      check("sel_active", 32'(sel), 32'(code));
      check("fill", 32'({s0, s3}), 32'(model_fill(op, fill, q)));
    end
    check("done_lat", 32'(k), 32'(exp_lat));
    check("sel_fin", 32'(sel), 32'(2'b11));
    check("busy_fin", 32'(busy), 32'(1));
    check("q_final", 32'(q), 32'(qexp));
    check("ovf_fin", 32'(ovf), 32'(oexp));
    @(negedge CLK);
    check("done_1cyc", 32'(done), 32'(0));
    check("ready_back", 32'(cmd_if.CMD_READY), 32'(1));
    check("ovf_hold", 32'(ovf), 32'(oexp));
    check("q_hold", 32'(q), 32'(qexp));
  endtask

  initial begin
    int acc[3];
    int base, t;
    RESET = 1'b1;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'b11;
    cmd_if.CMD_FILL  = 2'b00;
    cmd_if.CMD_COUNT = '0;
    repeat (3) @(negedge CLK);
    check("rst_sel", 32'(sel), 32'(2'b11));
    check("rst_s0s3", 32'({s0, s3}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_ready", 32'(cmd_if.CMD_READY), 32'(0));
    RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 32'(cmd_if.CMD_READY), 32'(1));

    run_cmd(2'b00, 2'b00, 0, 8'hA5);
    run_cmd(2'b00, 2'b00, 0, 8'h96);
    run_cmd(2'b01, 2'b11, 3, 8'h00);
    check("shr_arith_q", 32'(q), 32'(8'hF2));
    run_cmd(2'b00, 2'b00, 0, 8'h81);
    run_cmd(2'b10, 2'b10, 4, 8'h00);
    check("shl_rot_q", 32'(q), 32'(8'h18));
    run_cmd(2'b01, 2'b00, 0, 8'h00);
    run_cmd(2'b00, 2'b00, 0, 8'h40);
    run_cmd(2'b10, 2'b11, 2, 8'h00);
    check("shl_arith_ovf", 32'(ovf), 32'(1));
    run_cmd(2'b11, 2'b00, 0, 8'h00);

    // Held CMD_VALID: LOAD, SHR 1, NOP; acceptances spaced by their lengths.
    base = n_done;
    @(negedge CLK);
    load_data        = 8'h3C;
    cmd_if.CMD_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_if.CMD_OP    = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b11;
      cmd_if.CMD_FILL  = 2'b01;
      cmd_if.CMD_COUNT = CNT_W'(1);
      t = 0;
      while (!cmd_if.CMD_READY && t < 20) begin @(negedge CLK); t++; end
      acc[i] = cyc;
      @(posedge CLK);
      #1;
    end
    cmd_if.CMD_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'(3));
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'(3));
    check("b2b_dones", 32'(n_done - base), 32'(3));
    check("b2b_q", 32'(q), 32'(8'h9E));

    // Reset during the third SHIFT cycle of a count-10 shift.
    base = n_done;
    cmd_if.CMD_OP    = 2'b01;
    cmd_if.CMD_FILL  = 2'b00;
    cmd_if.CMD_COUNT = CNT_W'(10);
    cmd_if.CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    cmd_if.CMD_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_busy", 32'(busy), 32'(1));
    RESET = 1'b1;
    @(negedge CLK);
    check("mrst_sel", 32'(sel), 32'(2'b11));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_ready", 32'(cmd_if.CMD_READY), 32'(0));
    RESET = 1'b0;
    @(negedge CLK);
    check("mrst_ready_after", 32'(cmd_if.CMD_READY), 32'(1));
    repeat (12) @(negedge CLK);
    check("mrst_no_done", 32'(n_done - base), 32'(0));
    check("mrst_ovf", 32'(ovf), 32'(0));

    for (int i = 0; i < 60; i++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      run_cmd(2'($urandom), 2'($urandom), n, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
